axil2iob_bridge: RTL
====================

# axil2iob_bridge

AXI4-Lite slave to IOb master bridge with full handshake compliance: independent AW/W capture, registered B and R channels with back-pressure, round-robin read/write arbitration and a request timeout that returns SLVERR. It sits between an AXI4-Lite interconnect and IOb peripherals. It handles one IOb transaction at a time; AXI-side acceptance and responses are buffered so no AXI handshake is ever lost.

## Interface
- AXIL_ADDR_W, 32, AXI4-Lite address width
- AXIL_DATA_W, 32, AXI4-Lite data width; must equal DATA_W
- AXI_ID_W, 1, ID width of awid/bid/arid/rid
- ADDR_W, AXIL_ADDR_W, IOb address width; must not exceed AXIL_ADDR_W; addr_o = AXI addr[ADDR_W-1:0]
- DATA_W, AXIL_DATA_W, IOb data width
- TIMEOUT_W, 8, timeout counter width; 0 disables the timeout
- clk_i in 1 clock, all logic on rising edge
- arst_n_i in 1 asynchronous active-low reset
- axil_awid_i/awaddr_i/awvalid_i in AXI_ID_W/AXIL_ADDR_W/1; axil_awready_o out 1
- axil_wdata_i/wstrb_i/wvalid_i in AXIL_DATA_W/AXIL_DATA_W/8/1; axil_wready_o out 1
- axil_bid_o/bresp_o/bvalid_o out AXI_ID_W/2/1; axil_bready_i in 1
- axil_arid_i/araddr_i/arvalid_i in AXI_ID_W/AXIL_ADDR_W/1; axil_arready_o out 1
- axil_rid_o/rdata_o/rresp_o/rvalid_o out AXI_ID_W/AXIL_DATA_W/2/1; axil_rready_i in 1
- valid_o out 1, IOb request
- addr_o out ADDR_W, IOb address
- wdata_o out DATA_W, IOb write data
- wstrb_o out DATA_W/8; nonzero marks a write, zero marks a read
- rdata_i in DATA_W, IOb read data
- rvalid_i in 1, read data valid
- ready_i in 1, request accepted when valid_o & ready_i

## Operation
- Three capture registers, each with a full flag:
  - AW holds id and addr.
  - W holds data and strb.
  - AR holds id and addr.
- Ready signals:
  - awready_o = !aw_full.
  - wready_o = !w_full.
  - arready_o = !ar_full.
  - A register loads on its valid & ready handshake.
- AW and W may arrive in either order or in the same cycle. A write is pending when aw_full & w_full.
- A write with wstrb_i == 0 is still a write. It is issued with wstrb_o = 0 and completes with bresp OKAY without any IOb access.
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_WAIT, RD_RESP.
- IDLE transitions:
  - Write pending only goes to WR_REQ.
  - Read pending only goes to RD_REQ.
  - Both pending: grant the opposite of last_grant (reset value: read). last_grant updates on every grant.
- WR_REQ:
  - valid_o = 1, with addr/wdata/wstrb driven from the capture registers.
  - On ready_i: clear aw_full and w_full, load bresp = 2'b00 and bid, then go to WR_RESP.
- WR_RESP: bvalid_o = 1. On bready_i go to IDLE.
- RD_REQ:
  - valid_o = 1, wstrb_o = 0.
  - On ready_i: clear ar_full, then go to RD_WAIT.
- RD_WAIT: on rvalid_i, load rdata, rresp = 2'b00 and rid, then go to RD_RESP.
- RD_RESP: rvalid_o = 1. On rready_i go to IDLE.
- Timeout (TIMEOUT_W > 0):
  - The counter clears on entering WR_REQ, RD_REQ or RD_WAIT and increments each cycle spent in them.
  - At 2^TIMEOUT_W-1 the transaction aborts: valid_o drops, the capture registers clear, resp = 2'b10 (SLVERR), rdata = 0, and the FSM goes to WR_RESP or RD_RESP.
- rvalid_i outside RD_WAIT is ignored, including a late response after a timeout.
- valid_o is high only in WR_REQ and RD_REQ.
- B and R channel outputs hold stable while their valid is high and ready is low.

## Timing
- Reset values (all asynchronous on arst_n_i low):
  - FSM = IDLE.
  - All full flags = 0, so awready_o = wready_o = arready_o = 1.
  - valid_o = 0; addr_o, wdata_o, wstrb_o = 0.
  - bvalid_o = rvalid_o = 0; bresp, rresp, bid, rid, rdata = 0.
  - Timeout counter and last_grant reset as well.
- Write latency:
  - AW and W handshakes complete in cycle N.
  - valid_o is high in N+1.
  - With ready_i in N+1, bvalid_o is high in N+2.
- Read latency:
  - AR handshake completes in cycle N.
  - valid_o is high in N+1.
  - With ready_i in N+1 and rvalid_i in N+2, rvalid_o is high in N+3.
- rvalid_i is never expected in the same cycle as the ready_i that accepts the read.
- A new AW/W/AR may be captured while a transaction is in flight. This gives at most one write and one read buffered in addition to the active transaction.
- The capture registers clear on the ready_i cycle, so a new address can load in the following cycle.
- Reset mid-transaction aborts immediately. No response is generated.

## Test plan
- Single write, addr 0x10, data 0xDEADBEEF, strb 0xF, ready_i tied 1 -> valid_o one cycle with addr_o = 0x10, wstrb_o = 0xF; bvalid_o in the next cycle with bresp = 0, bid = awid.
- W arrives 3 cycles before AW -> wready_o low after W capture, no IOb request until AW arrives, then a single request with correct data.
- Read, addr 0x20, rvalid_i 2 cycles after ready_i with rdata 0x12345678, rready_i held low 5 cycles -> rvalid_o and rdata_o stable throughout; completes on rready_i.
- Write and read pending in the same cycle after reset -> write issued first, read issued after bvalid/bready; repeat to confirm alternation.
- ready_i held 0, TIMEOUT_W = 4 -> valid_o drops after 15 cycles; rresp or bresp = 2'b10, rdata_o = 0; a later rvalid_i is ignored.
- arst_n_i asserted during RD_WAIT -> all outputs at reset values; a fresh read after release completes normally.

Source files
------------

// File: rtl/axil2iob_bridge.sv
// AXI4-Lite slave to IOb master bridge: buffered AW/W/AR capture, one IOb
// transaction at a time, registered B/R responses and a request timeout.
module axil2iob_bridge #(
  parameter int AXIL_ADDR_W = 32,
  parameter int AXIL_DATA_W = 32,
  parameter int AXI_ID_W    = 1,
  parameter int ADDR_W      = AXIL_ADDR_W,
  parameter int DATA_W      = AXIL_DATA_W,
  parameter int TIMEOUT_W   = 8
) (
  input  logic                     clk_i,
  input  logic                     arst_n_i,
  input  logic [AXI_ID_W-1:0]      axil_awid_i,
  input  logic [AXIL_ADDR_W-1:0]   axil_awaddr_i,
  input  logic                     axil_awvalid_i,
  output logic                     axil_awready_o,
  input  logic [AXIL_DATA_W-1:0]   axil_wdata_i,
  input  logic [AXIL_DATA_W/8-1:0] axil_wstrb_i,
  input  logic                     axil_wvalid_i,
  output logic                     axil_wready_o,
  output logic [AXI_ID_W-1:0]      axil_bid_o,
  output logic [1:0]               axil_bresp_o,
  output logic                     axil_bvalid_o,
  input  logic                     axil_bready_i,
  input  logic [AXI_ID_W-1:0]      axil_arid_i,
  input  logic [AXIL_ADDR_W-1:0]   axil_araddr_i,
  input  logic                     axil_arvalid_i,
  output logic                     axil_arready_o,
  output logic [AXI_ID_W-1:0]      axil_rid_o,
  output logic [AXIL_DATA_W-1:0]   axil_rdata_o,
  output logic [1:0]               axil_rresp_o,
  output logic                     axil_rvalid_o,
  input  logic                     axil_rready_i,
  output logic                     valid_o,
  output logic [ADDR_W-1:0]        addr_o,
  output logic [DATA_W-1:0]        wdata_o,
  output logic [DATA_W/8-1:0]      wstrb_o,
  input  logic [DATA_W-1:0]        rdata_i,
  input  logic                     rvalid_i,
  input  logic                     ready_i
);

  localparam int CNT_W = (TIMEOUT_W > 0) ? TIMEOUT_W : 1;
  // Abort on the cycle the counter would reach all-ones.
  localparam logic [CNT_W-1:0] CNT_LIMIT = ~CNT_W'(1);
  localparam logic TMO_EN = (TIMEOUT_W > 0);

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_WAIT, RD_RESP} state_t;
  state_t state, state_n;

  logic                     aw_full, w_full, ar_full;
  logic [AXI_ID_W-1:0]      aw_id, ar_id, cur_id;
  logic [AXIL_ADDR_W-1:0]   aw_addr, ar_addr;
  logic [AXIL_DATA_W-1:0]   w_data;
  logic [AXIL_DATA_W/8-1:0] w_strb;
  logic                     aw_hs, w_hs, ar_hs;
  logic [AXI_ID_W-1:0]      aw_id_v, ar_id_v;
  logic [AXIL_ADDR_W-1:0]   aw_addr_v, ar_addr_v;
  logic [AXIL_DATA_W-1:0]   w_data_v;
  logic [AXIL_DATA_W/8-1:0] w_strb_v;
  logic                     wr_pend, rd_pend, timeout, last_rd;
  logic                     grant_wr, grant_rd, clr_wr, clr_rd, load_b, load_r, err;
  logic [CNT_W-1:0]         cnt;

  assign axil_awready_o = !aw_full;
  assign axil_wready_o  = !w_full;
  assign axil_arready_o = !ar_full;
  assign aw_hs = axil_awvalid_i & !aw_full;
  assign w_hs  = axil_wvalid_i & !w_full;
  assign ar_hs = axil_arvalid_i & !ar_full;

  // A handshake in this cycle counts as pending so IDLE can grant without a bubble.
  assign aw_id_v   = aw_full ? aw_id : axil_awid_i;
  assign aw_addr_v = aw_full ? aw_addr : axil_awaddr_i;
  assign w_data_v  = w_full ? w_data : axil_wdata_i;
  assign w_strb_v  = w_full ? w_strb : axil_wstrb_i;
  assign ar_id_v   = ar_full ? ar_id : axil_arid_i;
  assign ar_addr_v = ar_full ? ar_addr : axil_araddr_i;
  assign wr_pend   = (aw_full | aw_hs) & (w_full | w_hs);
  assign rd_pend   = ar_full | ar_hs;
  assign timeout   = TMO_EN & (cnt == CNT_LIMIT);

  // Capture registers and their full flags.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      aw_full <= 1'b0;
      w_full  <= 1'b0;
      ar_full <= 1'b0;
      aw_id   <= {AXI_ID_W{1'b0}};
      aw_addr <= {AXIL_ADDR_W{1'b0}};
      w_data  <= {AXIL_DATA_W{1'b0}};
      w_strb  <= {(AXIL_DATA_W/8){1'b0}};
      ar_id   <= {AXI_ID_W{1'b0}};
      ar_addr <= {AXIL_ADDR_W{1'b0}};
    end else begin
      if (aw_hs) begin
        aw_id   <= axil_awid_i;
        aw_addr <= axil_awaddr_i;
      end
      if (w_hs) begin
        w_data <= axil_wdata_i;
        w_strb <= axil_wstrb_i;
      end
      if (ar_hs) begin
        ar_id   <= axil_arid_i;
        ar_addr <= axil_araddr_i;
      end
      if (clr_wr) begin
        aw_full <= 1'b0;
        w_full  <= 1'b0;
      end else begin
        if (aw_hs) aw_full <= 1'b1;
        if (w_hs) w_full <= 1'b1;
      end
      if (clr_rd) ar_full <= 1'b0;
      else if (ar_hs) ar_full <= 1'b1;
    end
  end

  // Next-state, arbitration and completion strobes.
  always_comb begin
    state_n  = state;
    grant_wr = 1'b0;
    grant_rd = 1'b0;
    clr_wr   = 1'b0;
    clr_rd   = 1'b0;
    load_b   = 1'b0;
    load_r   = 1'b0;
    err      = 1'b0;
    case (state)
      IDLE: begin
        if (wr_pend && (!rd_pend || last_rd)) begin
          grant_wr = 1'b1;
          // An all-zero strobe write never touches IOb; answer OKAY directly.
          if (!(|w_strb_v)) begin
            clr_wr  = 1'b1;
            load_b  = 1'b1;
            state_n = WR_RESP;
          end else begin
            state_n = WR_REQ;
          end
        end else if (rd_pend) begin
          grant_rd = 1'b1;
          state_n  = RD_REQ;
        end else begin
          state_n = IDLE;
        end
      end
      WR_REQ: begin
        if (ready_i || timeout) begin
          clr_wr  = 1'b1;
          load_b  = 1'b1;
          err     = !ready_i;
          state_n = WR_RESP;
        end else begin
          state_n = WR_REQ;
        end
      end
      WR_RESP: begin
        if (axil_bready_i) state_n = IDLE;
        else state_n = WR_RESP;
      end
      RD_REQ: begin
        if (ready_i) begin
          clr_rd  = 1'b1;
          state_n = RD_WAIT;
        end else if (timeout) begin
          clr_rd  = 1'b1;
          load_r  = 1'b1;
          err     = 1'b1;
          state_n = RD_RESP;
        end else begin
          state_n = RD_REQ;
        end
      end
      RD_WAIT: begin
        if (rvalid_i || timeout) begin
          load_r  = 1'b1;
          err     = !rvalid_i;
          state_n = RD_RESP;
        end else begin
          state_n = RD_WAIT;
        end
      end
      RD_RESP: begin
        if (axil_rready_i) state_n = IDLE;
        else state_n = RD_RESP;
      end
      default: state_n = IDLE;
    endcase
  end

  // State register and timeout counter (cleared on every state change).
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state <= IDLE;
      cnt   <= {CNT_W{1'b0}};
    end else begin
      state <= state_n;
      if (state_n != state) cnt <= {CNT_W{1'b0}};
      else if (state == WR_REQ || state == RD_REQ || state == RD_WAIT) cnt <= cnt + CNT_W'(1);
      else cnt <= {CNT_W{1'b0}};
    end
  end

  // Registered IOb request, B/R response channels and arbitration history.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      valid_o       <= 1'b0;
      addr_o        <= {ADDR_W{1'b0}};
      wdata_o       <= {DATA_W{1'b0}};
      wstrb_o       <= {(DATA_W/8){1'b0}};
      cur_id        <= {AXI_ID_W{1'b0}};
      axil_bvalid_o <= 1'b0;
      axil_bresp_o  <= 2'b00;
      axil_bid_o    <= {AXI_ID_W{1'b0}};
      axil_rvalid_o <= 1'b0;
      axil_rresp_o  <= 2'b00;
      axil_rid_o    <= {AXI_ID_W{1'b0}};
      axil_rdata_o  <= {AXIL_DATA_W{1'b0}};
      last_rd       <= 1'b1;
    end else begin
      valid_o <= (state_n == WR_REQ) || (state_n == RD_REQ);
      if (grant_wr) begin
        addr_o  <= aw_addr_v[ADDR_W-1:0];
        wdata_o <= w_data_v;
        wstrb_o <= w_strb_v;
        cur_id  <= aw_id_v;
        last_rd <= 1'b0;
      end else if (grant_rd) begin
        addr_o  <= ar_addr_v[ADDR_W-1:0];
        wstrb_o <= {(DATA_W/8){1'b0}};
        cur_id  <= ar_id_v;
        last_rd <= 1'b1;
      end
      axil_bvalid_o <= (state_n == WR_RESP);
      if (load_b) begin
        axil_bresp_o <= err ? 2'b10 : 2'b00;
        axil_bid_o   <= grant_wr ? aw_id_v : cur_id;
      end
      axil_rvalid_o <= (state_n == RD_RESP);
      if (load_r) begin
        axil_rresp_o <= err ? 2'b10 : 2'b00;
        axil_rid_o   <= cur_id;
        axil_rdata_o <= err ? {AXIL_DATA_W{1'b0}} : rdata_i;
      end
    end
  end

endmodule
